// File: rtl/coax_tx.sv
// ---------------------------------------------------------------------------
// coax_tx -- 3270 coax transmitter.
// Turns 10-bit words from the control block into one bi-phase frame:
// line quiesce, code violation, then per word a sync bit, 10 data bits
// (MSB first) and an even-parity bit, then the ending sequence. Words
// queued before the last parity clock run back-to-back in the same frame.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   data[9:0]    word to send, MSB first
//   strobe       one-cycle send request, taken only while ready=1
//   ready        holding register empty
//   active       frame in progress
//   tx           bi-phase line level
//   tx_inverted  complement driver (0 outside a frame)
//   tx_delay     tx delayed by DELAY_CLOCKS clocks (pre-emphasis driver)
// ---------------------------------------------------------------------------
module coax_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 16,
  parameter int unsigned DELAY_CLOCKS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       strobe,
  output logic       ready,
  output logic       active,
  output logic       tx,
  output logic       tx_inverted,
  output logic       tx_delay
);

  localparam int unsigned CW   = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned HALF = CLOCKS_PER_BIT / 2;
  localparam int unsigned LAST = CLOCKS_PER_BIT - 1;
  localparam int unsigned DW   = DELAY_CLOCKS;
  localparam int unsigned BW   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_VIOLATION,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_END
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cell_q, cell_d;     // clock within current bit cell
  logic [BW-1:0]   bit_q, bit_d;       // bit cell index within current state
  logic [9:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [9:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            ready_q, ready_d;
  logic            active_q, active_d;
  logic            tx_q, tx_d;
  logic            tx_inv_q, tx_inv_d;
  logic [DW-1:0]   dly_q, dly_d;

  logic            accept;
  logic            cell_end;
  logic            xfer;

  // Level of a bi-phase bit: complement in the first half, true value in the second.
  function automatic logic cell_level(input logic b, input logic [CW-1:0] c);
    return (c < CW'(HALF)) ? ~b : b;
  endfunction

  assign accept   = strobe && ready_q;
  assign cell_end = (cell_q == CW'(LAST));
  // Holding word moves to the shifter on the first clock of each sync bit.
  assign xfer     = (state_q == S_SYNC) && (cell_q == '0) && hold_full_q;

  // Frame sequencing and bit-cell counters.
  always_comb begin
    state_d = state_q;
    cell_d  = cell_end ? '0 : cell_q + CW'(1);
    bit_d   = cell_end ? bit_q + BW'(1) : bit_q;
    case (state_q)
      S_IDLE: begin
        cell_d = '0;
        bit_d  = '0;
        if (hold_full_q || accept) state_d = S_QUIESCE;
      end
      S_QUIESCE: begin
        if (cell_end && (bit_q == BW'(4))) state_d = S_VIOLATION;
      end
      S_VIOLATION: begin
        if (cell_end && (bit_q == BW'(2))) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (cell_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (cell_end && (bit_q == BW'(9))) state_d = S_PARITY;
      end
      S_PARITY: begin
        // A strobe landing on the very last parity clock still chains on.
        if (cell_end) state_d = (hold_full_q || accept) ? S_SYNC : S_END;
      end
      S_END: begin
        // One "0" cell, then 1.5 cells high.
        if ((bit_q == BW'(2)) && (cell_q == CW'(HALF - 1))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      cell_d = '0;
      bit_d  = '0;
    end
  end

  // Holding register, shifter and parity.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    if (xfer) begin
      shift_d     = hold_q;
      par_d       = ^hold_q;
      hold_full_d = 1'b0;
    end else if ((state_q == S_DATA) && cell_end) begin
      shift_d = {shift_q[8:0], 1'b0};
    end
    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end
    ready_d = ~hold_full_d;
  end

  // Line level for the cycle being entered, so tx lines up with state_q.
  always_comb begin
    tx_d = 1'b0;
    case (state_d)
      S_IDLE:      tx_d = 1'b0;
      S_QUIESCE:   tx_d = cell_level(1'b1, cell_d);
      S_VIOLATION: tx_d = (bit_d == BW'(0)) ||
                          ((bit_d == BW'(1)) && (cell_d < CW'(HALF)));
      S_SYNC:      tx_d = cell_level(1'b1, cell_d);
      S_DATA:      tx_d = cell_level(shift_d[9], cell_d);
      S_PARITY:    tx_d = cell_level(par_d, cell_d);
      S_END:       tx_d = (bit_d == BW'(0)) ? cell_level(1'b0, cell_d) : 1'b1;
      default:     tx_d = 1'b0;
    endcase
    active_d = (state_d != S_IDLE);
    tx_inv_d = active_d & ~tx_d;
    // Delay line oldest bit falls off the top.
    dly_d    = DW'({dly_q, tx_q});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cell_q      <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
      tx_q        <= 1'b0;
      tx_inv_q    <= 1'b0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      tx_q        <= tx_d;
      tx_inv_q    <= tx_inv_d;
      dly_q       <= dly_d;
    end
  end

  assign ready       = ready_q;
  assign active      = active_q;
  assign tx          = tx_q;
  assign tx_inverted = tx_inv_q;
  assign tx_delay    = dly_q[DW-1];

endmodule

// File: tb/tb_coax_tx.sv
// ---------------------------------------------------------------------------
// tb_coax_tx -- scoreboard bench for coax_tx.
// Stimulus pushes the expected frame (words, hand-computed parity, length)
// when it strobes; monitors capture each active burst on the line and
// compare it with the popped record. Two instances: N=16/D=4 and N=8/D=2.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coax_tx;

  localparam int N  = 16;
  localparam int D  = 4;
  localparam int N8 = 8;
  localparam int D8 = 2;

  typedef struct packed {
    logic [3:0][9:0] w;
    logic [3:0]      p;
    logic [2:0]      nw;
    logic [15:0]     len;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data = '0;
  logic       strobe = 1'b0;
  logic       ready, active, tx, tx_inv, tx_dly;
  logic [9:0] data8 = '0;
  logic       strobe8 = 1'b0;
  logic       ready8, active8, tx8, tx_inv8, tx_dly8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  coax_tx #(.CLOCKS_PER_BIT(N), .DELAY_CLOCKS(D)) u_dut (
    .clk(clk), .reset(rst_n), .data(data), .strobe(strobe),
    .ready(ready), .active(active), .tx(tx),
    .tx_inverted(tx_inv), .tx_delay(tx_dly)
  );

  coax_tx #(.CLOCKS_PER_BIT(N8), .DELAY_CLOCKS(D8)) u_dut8 (
    .clk(clk), .reset(rst_n), .data(data8), .strobe(strobe8),
    .ready(ready8), .active(active8), .tx(tx8),
    .tx_inverted(tx_inv8), .tx_delay(tx_dly8)
  );

  function automatic void check1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void checkn(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic frame_t mk(input logic [9:0] w0, input logic p0,
                                input logic [9:0] w1, input logic p1,
                                input int nw, input int len);
    frame_t f;
    f      = '0;
    f.w[0] = w0;
    f.p[0] = p0;
    f.w[1] = w1;
    f.p[1] = p1;
    f.nw   = 3'(nw);
    f.len  = 16'(len);
    return f;
  endfunction

  // Reference line waveform for a frame; returns the count of differing cycles.
  function automatic int wave_errs(input frame_t f, input int n, input bit cap[$],
                                   output int first);
    bit e[$];
    int errs;
    logic [11:0] cb;
    errs  = 0;
    first = -1;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < n; k++) e.push_back(k >= n / 2);
    for (int k = 0; k < 3 * n; k++) e.push_back(k < 3 * n / 2);
    for (int j = 0; j < int'(f.nw); j++) begin
      cb = {1'b1, f.w[j], f.p[j]};
      for (int b = 11; b >= 0; b--)
        for (int k = 0; k < n; k++) e.push_back((k < n / 2) ? ~cb[b] : cb[b]);
    end
    for (int k = 0; k < n; k++) e.push_back(k < n / 2);
    for (int k = 0; k < 3 * n / 2; k++) e.push_back(1'b1);
    for (int i = 0; i < e.size() && i < cap.size(); i++) begin
      if (e[i] !== cap[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    return errs;
  endfunction

  frame_t exp_q[$];
  frame_t exp8_q[$];

  // Monitor for the N=16 instance.
  bit         cap[$];
  logic [D-1:0] txh;
  logic       prev_act;
  frame_t     mf;
  int         m_errs, m_first;
  always @(negedge clk) begin
    if (!rst_n) begin
      cap.delete();
      txh      = '0;
      prev_act = 1'b0;
    end else begin
      check1("tx_delay", tx_dly, txh[D-1]);
      if (active) begin
        check1("tx_inverted", tx_inv, ~tx);
        cap.push_back(tx);
      end else begin
        check1("idle_tx", tx, 1'b0);
        check1("idle_tx_inverted", tx_inv, 1'b0);
      end
      if (prev_act && !active) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got %0d active cycles want no frame", cap.size());
        end else begin
          mf = exp_q.pop_front();
          checkn("frame_len", cap.size(), int'(mf.len));
          m_errs = wave_errs(mf, N, cap, m_first);
          n_cmp++;
          if (m_errs != 0) begin
            n_bad++;
            $display("FAIL frame_wave: %0d bad cycles, first at %0d got %0b want %0b",
                     m_errs, m_first, cap[m_first], ~cap[m_first]);
          end
        end
        cap.delete();
      end
      prev_act = active;
      txh      = {txh[D-2:0], tx};
    end
  end

  // Monitor for the N=8 instance.
  bit          cap8[$];
  logic [D8-1:0] txh8;
  logic        prev_act8;
  frame_t      mf8;
  int          m8_errs, m8_first;
  always @(negedge clk) begin
    if (!rst_n) begin
      cap8.delete();
      txh8      = '0;
      prev_act8 = 1'b0;
    end else begin
      check1("n8_tx_delay", tx_dly8, txh8[D8-1]);
      if (active8) begin
        check1("n8_tx_inverted", tx_inv8, ~tx8);
        cap8.push_back(tx8);
      end else begin
        check1("n8_idle_tx", tx8, 1'b0);
      end
      if (prev_act8 && !active8) begin
        if (exp8_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL n8_unexpected_frame: got %0d active cycles want no frame", cap8.size());
        end else begin
          mf8 = exp8_q.pop_front();
          checkn("n8_frame_len", cap8.size(), int'(mf8.len));
          m8_errs = wave_errs(mf8, N8, cap8, m8_first);
          n_cmp++;
          if (m8_errs != 0) begin
            n_bad++;
            $display("FAIL n8_frame_wave: %0d bad cycles, first at %0d got %0b want %0b",
                     m8_errs, m8_first, cap8[m8_first], ~cap8[m8_first]);
          end
        end
        cap8.delete();
      end
      prev_act8 = active8;
      txh8      = {txh8[D8-2:0], tx8};
    end
  end

  // Called #1 after an edge; the strobe is sampled at the next edge.
  task automatic pulse(input logic [9:0] d);
    strobe = 1'b1;
    data   = d;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic pulse8(input logic [9:0] d);
    strobe8 = 1'b1;
    data8   = d;
    @(posedge clk); #1;
    strobe8 = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int c;
    c = 0;
    while ((active || !ready || active8 || !ready8) && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= limit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got still busy after %0d cycles want idle", name, c);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input int limit);
    int c;
    c = 0;
    while (!ready && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= limit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got ready=0 after %0d cycles want ready=1", name, c);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act_seen;

    // Reset and release.
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check1("rst_ready", ready, 1'b1);
    check1("rst_active", active, 1'b0);
    check1("rst_tx", tx, 1'b0);
    check1("rst_tx_inverted", tx_inv, 1'b0);
    check1("rst_tx_delay", tx_dly, 1'b0);

    // Single word 2A5 (five ones -> parity 1), 360 active cycles.
    exp_q.push_back(mk(10'h2A5, 1'b1, 10'h000, 1'b0, 1, 360));
    pulse(10'h2A5);
    check1("t1_active_c1", active, 1'b1);
    check1("t1_ready_c1", ready, 1'b0);
    repeat (128) @(posedge clk);
    #1 check1("t1_ready_c129", ready, 1'b0);
    @(posedge clk); #1;
    check1("t1_ready_c130", ready, 1'b1);
    repeat (230) @(posedge clk);
    #1 check1("t1_active_c360", active, 1'b1);
    @(posedge clk); #1;
    check1("t1_active_c361", active, 1'b0);
    wait_idle("t1", 1000);

    // Two words in one frame, second strobed as soon as ready returns.
    exp_q.push_back(mk(10'h000, 1'b0, 10'h3FF, 1'b0, 2, 552));
    pulse(10'h000);
    wait_ready("t2", 300);
    pulse(10'h3FF);
    wait_idle("t2", 1000);

    // Strobe on the last parity clock chains with no END.
    exp_q.push_back(mk(10'h0F0, 1'b0, 10'h001, 1'b1, 2, 552));
    pulse(10'h0F0);
    repeat (319) @(posedge clk);
    #1 pulse(10'h001);
    wait_idle("t3a", 1000);

    // One cycle later: END is sent and the word opens a new frame after IDLE.
    exp_q.push_back(mk(10'h3C0, 1'b0, 10'h000, 1'b0, 1, 360));
    exp_q.push_back(mk(10'h155, 1'b1, 10'h000, 1'b0, 1, 360));
    pulse(10'h3C0);
    repeat (320) @(posedge clk);
    #1 pulse(10'h155);
    repeat (38) @(posedge clk);
    #1 check1("t3b_active_c360", active, 1'b1);
    @(posedge clk); #1;
    check1("t3b_active_c361", active, 1'b0);
    @(posedge clk); #1;
    check1("t3b_active_c362", active, 1'b1);
    wait_idle("t3b", 1000);

    // Strobe while busy is dropped.
    exp_q.push_back(mk(10'h1C3, 1'b1, 10'h000, 1'b0, 1, 360));
    pulse(10'h1C3);
    repeat (9) @(posedge clk);
    #1 check1("t4_ready_busy", ready, 1'b0);
    pulse(10'h155);
    wait_idle("t4", 1000);

    // Reset mid-DATA with a word queued: abort and discard.
    pulse(10'h2A5);
    wait_ready("t5", 300);
    pulse(10'h155);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check1("t5_rst_active", active, 1'b0);
    check1("t5_rst_tx", tx, 1'b0);
    check1("t5_rst_tx_inverted", tx_inv, 1'b0);
    check1("t5_rst_tx_delay", tx_dly, 1'b0);
    check1("t5_rst_ready", ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    act_seen = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (active) act_seen++;
    end
    checkn("t5_post_reset_active_cycles", act_seen, 0);

    // Narrow bit cell instance: 180 active clocks.
    exp8_q.push_back(mk(10'h2A5, 1'b1, 10'h000, 1'b0, 1, 180));
    pulse8(10'h2A5);
    check1("t6_active8_c1", active8, 1'b1);
    wait_idle("t6", 1000);

    checkn("leftover_frames", exp_q.size(), 0);
    checkn("leftover_frames8", exp8_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
